// File: rtl/uart_apb_fifo.sv
// ---------------------------------------------------------------------------
// uart_apb_fifo
//
// APB-attached 8N1 UART with configurable-depth TX/RX FIFOs, a programmable
// 16-bit baud divisor, sticky error flags and a level interrupt. Zero-wait
// APB slave with a word-aligned register map:
//    0x00 DATA    write pushes TX FIFO, read pops RX FIFO
//    0x04 STATUS  [0] rx_nonempty [1] tx_full [2] tx_idle
//                 [3] rx_overrun (W1C) [4] framing_err (W1C)
//    0x08 CTRL    [0] tx_en [1] rx_en [2] rx_ie [3] tx_ie [4] loop (optional)
//    0x0C DIV     [15:0] bit period = DIV+1 clocks (minimum 4)
//    0x10 LEVEL   [15:0] TX count, [31:16] RX count
//
// Optional feature macro: UART_LOOPBACK_EN -- adds CTRL[4], which routes the
// internal TX serial stream into the receiver and holds the uart_tx pin high.
//
// Ports:
//    clock, reset         system clock (rising edge), async active-low reset
//    in_psel .. in_pstrb  APB slave port (in_pprot ignored, only pstrb[0] used)
//    uart_rx              asynchronous serial input
//    uart_tx              serial output, idle high
//    irq                  level interrupt, active high
// ---------------------------------------------------------------------------
module uart_apb_fifo #(
   parameter int          FIFO_DEPTH = 16,
   parameter logic [15:0] DIV_RESET  = 16'd867
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_psel,
   input  logic        in_penable,
   input  logic [2:0]  in_pprot,
   output logic        in_pready,
   output logic        in_pslverr,
   input  logic [31:0] in_paddr,
   input  logic        in_pwrite,
   output logic [31:0] in_prdata,
   input  logic [31:0] in_pwdata,
   input  logic [3:0]  in_pstrb,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        irq
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int TXF = 0;
   localparam int RXF = 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_STATUS = 3'd1;
   localparam logic [2:0] ADDR_CTRL   = 3'd2;
   localparam logic [2:0] ADDR_DIV    = 3'd3;
   localparam logic [2:0] ADDR_LEVEL  = 3'd4;

   // ------------------------------------------------------------------
   // APB decode
   // ------------------------------------------------------------------
   logic       access;
   logic       wr_access;
   logic       rd_access;
   logic       strb0;
   logic [2:0] reg_sel;
   logic       addr_ok;

   assign access    = in_psel & in_penable;
   assign in_pready = access;
   assign wr_access = access & in_pwrite;
   assign rd_access = access & ~in_pwrite;
   assign strb0     = in_pstrb[0];
   assign reg_sel   = in_paddr[4:2];
   assign addr_ok   = (reg_sel <= ADDR_LEVEL);

   logic unused_bits;
   assign unused_bits = ^{in_pprot, in_paddr[31:5], in_paddr[1:0],
                          in_pwdata[31:16], in_pstrb[3:1]};

   // ------------------------------------------------------------------
   // Control / status registers
   // ------------------------------------------------------------------
   logic [3:0]  ctrl_reg;
   logic [15:0] div_reg;
   logic        overrun_reg;
   logic        ferr_reg;
   logic        loop_en;
   logic [15:0] div_eff;

   logic tx_en, rx_en, rx_ie, tx_ie;
   assign tx_en = ctrl_reg[0];
   assign rx_en = ctrl_reg[1];
   assign rx_ie = ctrl_reg[2];
   assign tx_ie = ctrl_reg[3];

   // Divisors below 3 would leave no room for a mid-bit sample.
   assign div_eff = (div_reg < 16'd3) ? 16'd3 : div_reg;

   // ------------------------------------------------------------------
   // FIFOs: index TXF = transmit, RXF = receive. Head is read
   // combinationally so a DATA read returns it in the same access phase.
   // ------------------------------------------------------------------
   logic [1:0]          fifo_push;
   logic [1:0]          fifo_pop;
   logic [1:0][7:0]     fifo_wdata;
   logic [1:0][7:0]     fifo_head;
   logic [1:0][CW-1:0]  fifo_count;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
         logic [7:0]    mem [FIFO_DEPTH];
         logic [AW-1:0] wr_ptr_reg;
         logic [AW-1:0] rd_ptr_reg;
         logic [CW-1:0] count_reg;

         always_ff @(posedge clock) begin
            if (fifo_push[gi]) mem[wr_ptr_reg] <= fifo_wdata[gi];
         end

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
            end else begin
               if (fifo_push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
               if (fifo_pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
               case ({fifo_push[gi], fifo_pop[gi]})
                  2'b10:   count_reg <= count_reg + 1'b1;
                  2'b01:   count_reg <= count_reg - 1'b1;
                  default: count_reg <= count_reg;
               endcase
            end
         end

         assign fifo_head[gi]  = mem[rd_ptr_reg];
         assign fifo_count[gi] = count_reg;
      end
   endgenerate

   logic tx_full, tx_empty, rx_full, rx_empty;
   assign tx_full  = (fifo_count[TXF] == FULL_COUNT);
   assign tx_empty = (fifo_count[TXF] == '0);
   assign rx_full  = (fifo_count[RXF] == FULL_COUNT);
   assign rx_empty = (fifo_count[RXF] == '0);

   // ------------------------------------------------------------------
   // Transmitter
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   tx_state_t   tx_state_reg, tx_state_next;
   logic [15:0] tx_cnt_reg, tx_cnt_next;
   logic [2:0]  tx_bit_reg, tx_bit_next;
   logic [7:0]  tx_shift_reg, tx_shift_next;
   logic        tx_line_reg, tx_line_next;
   logic        tx_pop;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tx_state_reg <= TX_IDLE;
         tx_cnt_reg   <= '0;
         tx_bit_reg   <= '0;
         tx_shift_reg <= '0;
         tx_line_reg  <= 1'b1;
      end else begin
         tx_state_reg <= tx_state_next;
         tx_cnt_reg   <= tx_cnt_next;
         tx_bit_reg   <= tx_bit_next;
         tx_shift_reg <= tx_shift_next;
         tx_line_reg  <= tx_line_next;
      end
   end

   always_comb begin
      tx_state_next = tx_state_reg;
      tx_cnt_next   = tx_cnt_reg;
      tx_bit_next   = tx_bit_reg;
      tx_shift_next = tx_shift_reg;
      tx_pop        = 1'b0;
      // The line is registered from the current state, so it lags the
      // state register by one clock; every bit still lasts DIV+1 clocks.
      case (tx_state_reg)
         TX_START: tx_line_next = 1'b0;
         TX_DATA:  tx_line_next = tx_shift_reg[0];
         default:  tx_line_next = 1'b1;
      endcase

      case (tx_state_reg)
         TX_IDLE: begin
            if (tx_en && !tx_empty) begin
               tx_pop        = 1'b1;
               tx_shift_next = fifo_head[TXF];
               tx_cnt_next   = div_eff;
               tx_state_next = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt_reg == '0) begin
               tx_cnt_next   = div_eff;
               tx_bit_next   = '0;
               tx_state_next = TX_DATA;
            end else begin
               tx_cnt_next = tx_cnt_reg - 1'b1;
            end
         end
         TX_DATA: begin
            if (tx_cnt_reg == '0) begin
               tx_cnt_next   = div_eff;
               tx_shift_next = {1'b0, tx_shift_reg[7:1]};
               if (tx_bit_reg == 3'd7) begin
                  tx_state_next = TX_STOP;
               end else begin
                  tx_bit_next = tx_bit_reg + 1'b1;
               end
            end else begin
               tx_cnt_next = tx_cnt_reg - 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_cnt_reg == '0) begin
               // Chain straight into the next start bit when more data waits.
               if (tx_en && !tx_empty) begin
                  tx_pop        = 1'b1;
                  tx_shift_next = fifo_head[TXF];
                  tx_cnt_next   = div_eff;
                  tx_state_next = TX_START;
               end else begin
                  tx_state_next = TX_IDLE;
               end
            end else begin
               tx_cnt_next = tx_cnt_reg - 1'b1;
            end
         end
         default: tx_state_next = TX_IDLE;
      endcase
   end

   logic tx_idle;
   assign tx_idle = tx_empty & (tx_state_reg == TX_IDLE);

   // ------------------------------------------------------------------
   // Receiver
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t   rx_state_reg, rx_state_next;
   logic [15:0] rx_cnt_reg, rx_cnt_next;
   logic [2:0]  rx_bit_reg, rx_bit_next;
   logic [7:0]  rx_shift_reg, rx_shift_next;
   logic        rx_sync1_reg, rx_sync2_reg, rx_prev_reg;
   logic        rx_in;
   logic        rx_good;
   logic        rx_ferr;
   logic        rx_pop;

   assign rx_in = loop_en ? tx_line_reg : rx_sync2_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_sync1_reg <= 1'b1;
         rx_sync2_reg <= 1'b1;
         rx_prev_reg  <= 1'b1;
         rx_state_reg <= RX_IDLE;
         rx_cnt_reg   <= '0;
         rx_bit_reg   <= '0;
         rx_shift_reg <= '0;
      end else begin
         rx_sync1_reg <= uart_rx;
         rx_sync2_reg <= rx_sync1_reg;
         rx_prev_reg  <= rx_in;
         rx_state_reg <= rx_state_next;
         rx_cnt_reg   <= rx_cnt_next;
         rx_bit_reg   <= rx_bit_next;
         rx_shift_reg <= rx_shift_next;
      end
   end

   always_comb begin
      rx_state_next = rx_state_reg;
      rx_cnt_next   = rx_cnt_reg;
      rx_bit_next   = rx_bit_reg;
      rx_shift_next = rx_shift_reg;
      rx_good       = 1'b0;
      rx_ferr       = 1'b0;
      case (rx_state_reg)
         RX_IDLE: begin
            if (rx_prev_reg && !rx_in) begin
               // Half a period to land the first sample mid start bit.
               rx_cnt_next   = div_eff >> 1;
               rx_state_next = RX_START;
            end
         end
         RX_START: begin
            if (rx_cnt_reg == '0) begin
               if (rx_in) begin
                  rx_state_next = RX_IDLE;
               end else begin
                  rx_cnt_next   = div_eff;
                  rx_bit_next   = '0;
                  rx_state_next = RX_DATA;
               end
            end else begin
               rx_cnt_next = rx_cnt_reg - 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_reg == '0) begin
               rx_shift_next = {rx_in, rx_shift_reg[7:1]};
               rx_cnt_next   = div_eff;
               if (rx_bit_reg == 3'd7) begin
                  rx_state_next = RX_STOP;
               end else begin
                  rx_bit_next = rx_bit_reg + 1'b1;
               end
            end else begin
               rx_cnt_next = rx_cnt_reg - 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_reg == '0) begin
               rx_state_next = RX_IDLE;
               if (rx_in) rx_good = 1'b1;
               else       rx_ferr = 1'b1;
            end else begin
               rx_cnt_next = rx_cnt_reg - 1'b1;
            end
         end
         default: rx_state_next = RX_IDLE;
      endcase
      if (!rx_en) begin
         rx_state_next = RX_IDLE;
         rx_good       = 1'b0;
         rx_ferr       = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // FIFO hookup. A full FIFO still accepts when it is popped in the same
   // cycle: the write lands in the slot the pop is vacating.
   // ------------------------------------------------------------------
   logic sel_data;
   logic rx_overrun_set;

   assign sel_data = (reg_sel == ADDR_DATA);
   assign rx_pop   = rd_access & sel_data & ~rx_empty;

   assign fifo_wdata[TXF] = in_pwdata[7:0];
   assign fifo_push[TXF]  = wr_access & sel_data & strb0 & (~tx_full | tx_pop);
   assign fifo_pop[TXF]   = tx_pop;

   assign fifo_wdata[RXF] = rx_shift_reg;
   assign fifo_push[RXF]  = rx_good & (~rx_full | rx_pop);
   assign fifo_pop[RXF]   = rx_pop;
   assign rx_overrun_set  = rx_good & rx_full & ~rx_pop;

   // ------------------------------------------------------------------
   // Register writes and sticky flags (set wins over a same-cycle clear)
   // ------------------------------------------------------------------
   logic reg_wr;
   assign reg_wr = wr_access & strb0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ctrl_reg    <= '0;
         div_reg     <= DIV_RESET;
         overrun_reg <= 1'b0;
         ferr_reg    <= 1'b0;
      end else begin
         if (reg_wr && reg_sel == ADDR_CTRL) ctrl_reg <= in_pwdata[3:0];
         if (reg_wr && reg_sel == ADDR_DIV)  div_reg  <= in_pwdata[15:0];
         if (reg_wr && reg_sel == ADDR_STATUS && in_pwdata[3]) overrun_reg <= 1'b0;
         if (reg_wr && reg_sel == ADDR_STATUS && in_pwdata[4]) ferr_reg    <= 1'b0;
         if (rx_overrun_set) overrun_reg <= 1'b1;
         if (rx_ferr)        ferr_reg    <= 1'b1;
      end
   end

`ifdef UART_LOOPBACK_EN
   logic loop_reg;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         loop_reg <= 1'b0;
      end else if (reg_wr && reg_sel == ADDR_CTRL) begin
         loop_reg <= in_pwdata[4];
      end
   end
   assign loop_en = loop_reg;
`else
   assign loop_en = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Read mux and error response, both combinational in the access phase
   // ------------------------------------------------------------------
   always_comb begin
      in_prdata  = '0;
      in_pslverr = 1'b0;
      if (access) begin
         if (!addr_ok) begin
            in_pslverr = 1'b1;
         end else if (in_pwrite) begin
            if (sel_data && strb0 && tx_full && !tx_pop) in_pslverr = 1'b1;
         end else begin
            case (reg_sel)
               ADDR_DATA: begin
                  if (rx_empty) in_pslverr = 1'b1;
                  else          in_prdata  = {24'd0, fifo_head[RXF]};
               end
               ADDR_STATUS: in_prdata = {27'd0, ferr_reg, overrun_reg, tx_idle,
                                         tx_full, ~rx_empty};
               ADDR_CTRL:   in_prdata = {27'd0, loop_en, ctrl_reg};
               ADDR_DIV:    in_prdata = {16'd0, div_reg};
               default:     in_prdata = {16'(fifo_count[RXF]), 16'(fifo_count[TXF])};
            endcase
         end
      end
   end

   assign uart_tx = loop_en ? 1'b1 : tx_line_reg;
   assign irq     = (rx_ie & ~rx_empty) | (tx_ie & tx_empty);

endmodule

// File: tb/tb_uart_apb_fifo.sv
`timescale 1ns/1ps
module tb_uart_apb_fifo;

   localparam int DEPTH = 16;
   localparam logic [31:0] A_DATA   = 32'h00;
   localparam logic [31:0] A_STATUS = 32'h04;
   localparam logic [31:0] A_CTRL   = 32'h08;
   localparam logic [31:0] A_DIV    = 32'h0C;
   localparam logic [31:0] A_LEVEL  = 32'h10;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [2:0]  pprot = 3'd0;
   logic [31:0] paddr = '0, pwdata = '0;
   logic [3:0]  pstrb = 4'h0;
   logic        pready, pslverr;
   logic [31:0] prdata;
   logic        uart_rx = 1'b1;
   logic        uart_tx, irq;
   logic        last_pready;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   uart_apb_fifo #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd867)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_psel    (psel),
      .in_penable (penable),
      .in_pprot   (pprot),
      .in_pready  (pready),
      .in_pslverr (pslverr),
      .in_paddr   (paddr),
      .in_pwrite  (pwrite),
      .in_prdata  (prdata),
      .in_pwdata  (pwdata),
      .in_pstrb   (pstrb),
      .uart_rx    (uart_rx),
      .uart_tx    (uart_tx),
      .irq        (irq)
   );

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, output logic [31:0] rdata, output logic err);
      @(posedge clock); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
      @(posedge clock); #1;
      penable = 1'b1;
      @(negedge clock);
      rdata = prdata; err = pslverr; last_pready = pready;
      @(posedge clock); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = 4'h0;
      $display("apb %s addr=%h wdata=%h rdata=%h err=%0b", wr ? "WR" : "RD", addr, data, rdata, err);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] r;
      logic e;
      apb(1'b1, addr, data, 4'hF, r, e);
   endtask

   task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic err);
      apb(1'b0, addr, 32'd0, 4'h0, data, err);
   endtask

   // Waits for a start bit, then samples every bit at its midpoint.
   // 'waited' is the number of clocks spent waiting for the falling edge.
   task automatic capture_frame(input int p, output logic [7:0] data, output logic stop_bit,
                                output logic start_ok, output int waited);
      waited = 0;
      while (uart_tx !== 1'b0 && waited < 20 * p + 50) begin
         tick(1);
         waited++;
      end
      tick(p / 2);
      start_ok = (uart_tx === 1'b0);
      for (int k = 0; k < 8; k++) begin
         tick(p);
         data[k] = uart_tx;
      end
      tick(p);
      stop_bit = uart_tx;
      $display("tx frame data=%h stop=%0b start_ok=%0b waited=%0d", data, stop_bit, start_ok, waited);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_val, input int p);
      logic [9:0] f;
      f = {stop_val, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         uart_rx = f[k];
         tick(p);
      end
      uart_rx = 1'b1;
      $display("rx frame sent data=%h stop=%0b period=%0d", b, stop_val, p);
   endtask

   function automatic int period_of(input int d);
      return ((d < 3) ? 3 : d) + 1;
   endfunction

   initial begin : main
      logic [31:0] r;
      logic        e;
      logic [7:0]  b, got;
      logic        stp, sok, all_hi;
      int          w, p, d, nb;
      logic [39:0] s;
      logic [9:0]  fr;
      logic [7:0]  txq[$];
      logic [7:0]  rxq[$];

      // ---------------- reset ----------------
      #2 reset = 1'b0;
      tick(3);
      check("rst_uart_tx", uart_tx, 1'b1);
      check("rst_irq", irq, 1'b0);
      check("rst_prdata", prdata, 32'd0);
      check("rst_pslverr", pslverr, 1'b0);
      reset = 1'b1;
      tick(2);
      rd(A_DIV, r, e);    check("rst_div", r, 32'd867);
      check("pready_access", last_pready, 1'b1);
      rd(A_CTRL, r, e);   check("rst_ctrl", r, 32'd0);
      rd(A_STATUS, r, e); check("rst_status", r, 32'h04);
      rd(A_LEVEL, r, e);  check("rst_level", r, 32'd0);

      // ---------------- bad offsets ----------------
      rd(32'h14, r, e);   check("bad_rd_data", r, 32'd0); check("bad_rd_err", e, 1'b1);
      apb(1'b1, 32'h1C, 32'hFF, 4'hF, r, e); check("bad_wr_err", e, 1'b1);

      // ---------------- single frame 0xA5 at DIV=3 ----------------
      wr(A_DIV, 32'd3);
      wr(A_CTRL, 32'h1);
      wr(A_DATA, 32'hA5);
      tick(1);
      check("tx_before_start", uart_tx, 1'b1);
      for (int i = 0; i < 40; i++) begin
         tick(1);
         s[i] = uart_tx;
      end
      fr = {1'b1, 8'hA5, 1'b0};
      for (int k = 0; k < 10; k++) check("tx_a5_bit", s[4*k +: 4], {4{fr[k]}});
      rd(A_STATUS, r, e); check("tx_a5_idle", r, 32'h04);

      // ---------------- TX FIFO fill past full ----------------
      wr(A_CTRL, 32'h0);
      d = $urandom_range(0, 2);
      p = period_of(d);
      wr(A_DIV, d);
      for (int i = 0; i <= DEPTH; i++) begin
         b = 8'($urandom);
         apb(1'b1, A_DATA, {24'd0, b}, 4'hF, r, e);
         if (i < DEPTH) txq.push_back(b);
         check("tx_push_err", e, (i >= DEPTH) ? 1'b1 : 1'b0);
      end
      rd(A_LEVEL, r, e);  check("tx_full_level", r, 32'(DEPTH));
      rd(A_STATUS, r, e); check("tx_full_flag", r[1], 1'b1);
      apb(1'b1, A_DATA, 32'h77, 4'hE, r, e); check("tx_nostrb_err", e, 1'b0);
      rd(A_LEVEL, r, e);  check("tx_nostrb_level", r, 32'(DEPTH));
      wr(A_CTRL, 32'h1);
      for (int i = 0; i < DEPTH; i++) begin
         capture_frame(p, got, stp, sok, w);
         b = txq.pop_front();
         check("tx_burst_start", sok, 1'b1);
         check("tx_burst_data", got, b);
         check("tx_burst_stop", stp, 1'b1);
         if (i > 0) check("tx_burst_gap", w, p - p / 2);
      end

      // ---------------- randomized TX rounds ----------------
      for (int round = 0; round < 3; round++) begin
         wr(A_CTRL, 32'h0);
         d = $urandom_range(0, 8);
         p = period_of(d);
         wr(A_DIV, d);
         nb = $urandom_range(1, 4);
         for (int i = 0; i < nb; i++) begin
            b = 8'($urandom);
            wr(A_DATA, {24'd0, b});
            txq.push_back(b);
         end
         wr(A_CTRL, 32'h1);
         for (int i = 0; i < nb; i++) begin
            capture_frame(p, got, stp, sok, w);
            b = txq.pop_front();
            check("tx_rand_start", sok, 1'b1);
            check("tx_rand_data", got, b);
            check("tx_rand_stop", stp, 1'b1);
         end
      end
      tick(12);
      wr(A_CTRL, 32'h8);
      tick(1); check("irq_tx_empty", irq, 1'b1);
      wr(A_CTRL, 32'h0);
      tick(1); check("irq_off", irq, 1'b0);

      // ---------------- single RX byte 0x3C at DIV=7 ----------------
      wr(A_DIV, 32'd7);
      wr(A_CTRL, 32'h6);
      send_frame(8'h3C, 1'b1, 8);
      tick(4);
      check("rx_irq", irq, 1'b1);
      rd(A_STATUS, r, e); check("rx_status", r, 32'h05);
      rd(A_DATA, r, e);   check("rx_data", r, 32'h3C); check("rx_data_err", e, 1'b0);
      rd(A_DATA, r, e);   check("rx_empty_data", r, 32'd0); check("rx_empty_err", e, 1'b1);
      tick(1); check("rx_irq_clear", irq, 1'b0);

      // ---------------- randomized RX ----------------
      d = $urandom_range(0, 9);
      p = period_of(d);
      wr(A_DIV, d);
      nb = $urandom_range(3, 8);
      for (int i = 0; i < nb; i++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1, p);
         rxq.push_back(b);
      end
      tick(4);
      rd(A_LEVEL, r, e); check("rx_rand_level", r, 32'(nb) << 16);
      while (rxq.size() > 0) begin
         b = rxq.pop_front();
         rd(A_DATA, r, e); check("rx_rand_data", r, {24'd0, b});
      end

      // ---------------- RX overrun ----------------
      wr(A_DIV, 32'd3);
      for (int i = 0; i <= DEPTH; i++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1, 4);
         if (i < DEPTH) rxq.push_back(b);
      end
      tick(4);
      rd(A_STATUS, r, e); check("ovr_status", r, 32'h0D);
      rd(A_LEVEL, r, e);  check("ovr_level", r, 32'(DEPTH) << 16);
      wr(A_STATUS, 32'h08);
      rd(A_STATUS, r, e); check("ovr_w1c", r, 32'h05);
      while (rxq.size() > 0) begin
         b = rxq.pop_front();
         rd(A_DATA, r, e); check("ovr_data", r, {24'd0, b});
      end

      // ---------------- framing error and glitch ----------------
      send_frame(8'($urandom), 1'b0, 4);
      tick(4);
      rd(A_LEVEL, r, e);  check("ferr_level", r, 32'd0);
      rd(A_STATUS, r, e); check("ferr_status", r, 32'h14);
      wr(A_STATUS, 32'h10);
      rd(A_STATUS, r, e); check("ferr_w1c", r, 32'h04);
      uart_rx = 1'b0;
      tick(1);
      uart_rx = 1'b1;
      tick(16);
      rd(A_LEVEL, r, e);  check("glitch_level", r, 32'd0);
      rd(A_STATUS, r, e); check("glitch_status", r, 32'h04);

      // ---------------- loopback option ----------------
`ifdef UART_LOOPBACK_EN
      wr(A_CTRL, 32'h13);
      rd(A_CTRL, r, e); check("loop_ctrl", r, 32'h13);
      wr(A_DATA, 32'h5A);
      all_hi = 1'b1;
      for (int i = 0; i < 60; i++) begin
         tick(1);
         all_hi = all_hi & uart_tx;
      end
      check("loop_pin_high", all_hi, 1'b1);
      rd(A_DATA, r, e); check("loop_data", r, 32'h5A);
`else
      wr(A_CTRL, 32'h13);
      rd(A_CTRL, r, e); check("noloop_ctrl", r, 32'h03);
      all_hi = uart_tx;
      check("noloop_pin_idle", all_hi, 1'b1);
`endif
      wr(A_CTRL, 32'h0);

      // ---------------- reset mid-frame ----------------
      wr(A_DIV, 32'd3);
      wr(A_CTRL, 32'h1);
      wr(A_DATA, 32'h00);
      wr(A_DATA, 32'h81);
      check("midrst_line_low", uart_tx, 1'b0);
      #2 reset = 1'b0;
      #1;
      check("midrst_tx_high", uart_tx, 1'b1);
      check("midrst_irq", irq, 1'b0);
      tick(1);
      reset = 1'b1;
      rd(A_LEVEL, r, e); check("midrst_level", r, 32'd0);
      rd(A_DIV, r, e);   check("midrst_div", r, 32'd867);
      rd(A_CTRL, r, e);  check("midrst_ctrl", r, 32'd0);
      all_hi = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick(1);
         all_hi = all_hi & uart_tx;
      end
      check("midrst_line_idle", all_hi, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_apb_fifo.md
# uart_apb_fifo

Parametrised APB-attached 8N1 UART, the successor to the 16550-style APB wrapper in the peripheral tree. It replaces the byte-lane-decoded 16550 register file with a word-aligned register map, configurable-depth TX/RX FIFOs, a programmable 16-bit baud divisor, sticky error flags and a level interrupt. It sits on the SoC APB fabric as a zero-wait-state slave.

## Interface
- FIFO_DEPTH, 16, entries per FIFO; power of two, 4..256
- DIV_RESET, 16'd867, reset value of DIV register
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- in_psel  in  1  APB select
- in_penable  in  1  APB enable
- in_pprot  in  3  ignored
- in_pready  out  1  = in_psel & in_penable
- in_pslverr  out  1  error response, valid in access phase only
- in_paddr  in  32  byte address; [4:2] selects register
- in_pwrite  in  1  1 = write
- in_prdata  out  32  read data, 0 outside access phase
- in_pwdata  in  32  write data
- in_pstrb  in  4  write strobes; only pstrb[0] honoured
- uart_rx  in  1  serial input, asynchronous
- uart_tx  out  1  serial output, idle high
- irq  out  1  level interrupt, active high

## Operation
- Registers (offset): 0x00 DATA, 0x04 STATUS, 0x08 CTRL, 0x0C DIV, 0x10 LEVEL; any other offset -> prdata 0, pslverr 1, no side effect.
- DATA write with pstrb[0]=1 pushes pwdata[7:0] to TX FIFO; pstrb[0]=0 -> ignored, no error. Write when TX full -> pslverr 1, byte dropped, unless the transmitter pops in the same cycle (then accepted).
- DATA read pops RX FIFO, prdata[7:0] = head; RX empty -> prdata 0, pslverr 1, no pop.
- STATUS (RO except W1C): [0] rx_nonempty, [1] tx_full, [2] tx_idle (TX FIFO empty and shifter idle), [3] rx_overrun sticky, [4] framing_err sticky; writing 1 to [3]/[4] clears.
- CTRL, reset 0: [0] tx_en, [1] rx_en, [2] rx_ie, [3] tx_ie.
- DIV[15:0]: bit period = DIV+1 clocks; values below 3 behave as 3. DIV is read on every bit-counter reload.
- LEVEL (RO): [15:0] TX count, [31:16] RX count.
- All side effects (push, pop, W1C, register writes) occur once, on the access-phase edge (psel & penable).
- TX FSM IDLE -> START -> DATA(8, LSB first) -> STOP -> IDLE/START. Leaves IDLE when tx_en and TX nonempty (pops). After STOP, starts next frame with no idle gap if conditions hold. Clearing tx_en mid-frame finishes the current frame.
- RX: uart_rx through 2-flop synchroniser (reset 1). FSM IDLE -> START -> DATA -> STOP. Falling edge in IDLE with rx_en starts; sample at half period; start sampled 1 -> back to IDLE (glitch). Data sampled mid-bit. Stop sampled 0 -> byte discarded, framing_err set. Stop 1 -> push; if RX full and no same-cycle APB pop -> byte dropped, rx_overrun set. Clearing rx_en aborts to IDLE.
- irq = (rx_ie & rx_nonempty) | (tx_ie & TX FIFO empty).
- Both FIFOs: simultaneous push and pop -> count unchanged; pointers wrap modulo FIFO_DEPTH; count width covers FIFO_DEPTH (full = count==FIFO_DEPTH).

## Timing
- Reset values: uart_tx 1, irq 0, in_prdata 0, in_pslverr 0, FIFOs empty, CTRL 0, DIV DIV_RESET, sticky flags 0, both FSMs IDLE.
- in_pready combinational, no wait states; prdata/pslverr combinational in access phase.
- TX latency: with tx_en and idle, uart_tx falls on the 2nd rising edge after the DATA write access edge; frame = 10×(DIV+1) clocks.
- RX latency: rx_nonempty rises 3 clocks after mid-stop-bit sample point (2 sync + push).
- Reset assertion mid-frame: immediate abort, uart_tx 1 asynchronously, FIFO contents lost.

## Configuration
- UART_LOOPBACK_EN defined: CTRL[4] loop bit (reset 0); when set, receiver input is internal TX serial stream (bypassing synchroniser), uart_tx pin held 1.
- Undefined: CTRL[4] reads 0, writes ignored, no loopback path.

## Test plan
- DIV=3, tx_en=1, write 0xA5 -> uart_tx: start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 4 clocks; tx_idle=1 after 40 clocks.
- Write FIFO_DEPTH+1 bytes with tx_en=0 -> last write pslverr 1, LEVEL[15:0]=FIFO_DEPTH, tx_full=1.
- Drive 0x3C on uart_rx at DIV=7, rx_en=1, rx_ie=1 -> irq 1, DATA read 0x3C, then read with empty RX -> prdata 0, pslverr 1, irq 0.
- Send FIFO_DEPTH+1 frames without reading -> rx_overrun=1, RX count=FIFO_DEPTH; write STATUS 0x08 -> bit 3 clears.
- Frame with stop bit 0 -> no push, framing_err=1; 1-clock low glitch on idle line -> no push, no flag.
- UART_LOOPBACK_EN, CTRL=0x13, write 0x5A -> uart_tx stays 1, DATA read 0x5A after one frame.
